instruction_fetch_unit: RTL and testbench

Bus-side producer of the 32-bit instruction word consumed by the instruction decoder. It owns the fetch PC and issues word-sized reads on the CPU's bus-master port. It buffers up to two fetched words with their addresses and hands the oldest to the core through a valid/consume handshake. A redirect input supplies branch, jump and exception targets as 30-bit word addresses.

---
 rtl/instruction_fetch_unit_pkg.sv | 14 +
 rtl/instruction_fetch_unit_if.sv | 11 +
 rtl/instruction_fetch_unit_queue.sv | 46 ++++
 rtl/instruction_fetch_unit.sv | 84 ++++++++
 tb/tb_instruction_fetch_unit.sv | 154 +++++++++++++++
 5 files changed

// File: rtl/instruction_fetch_unit_pkg.sv
// instruction_fetch_unit_pkg: shared CPU bus codes, reset vector and fetch queue types
package instruction_fetch_unit_pkg;
  localparam logic [1:0] BUS_SIZE_BYTE = 2'b00;
  localparam logic [1:0] BUS_SIZE_HALF = 2'b01;
  localparam logic [1:0] BUS_SIZE_WORD = 2'b10;
  localparam logic [31:0] RESET_VECTOR_DEFAULT = 32'hE000_0000;
  localparam int FETCH_QUEUE_DEPTH = 2;
  typedef enum logic {ST_RUN, ST_DRAIN} fetch_state_e;
  typedef struct packed {
    logic [31:0] data;
    logic [29:0] addr;
    logic fault;
  } fetch_entry_t;
endpackage

// File: rtl/instruction_fetch_unit_if.sv
// instruction_fetch_unit_if: word-read bus between the fetch unit (master) and memory (slave)
interface instruction_fetch_unit_if;
  logic busRequest;
  logic [31:0] busAddress;
  logic [1:0] busSize;
  logic busAcknowledge;
  logic [31:0] busReadData;
  logic busError;
  modport master(output busRequest, busAddress, busSize, input busAcknowledge, busReadData, busError);
  modport slave(input busRequest, busAddress, busSize, output busAcknowledge, busReadData, busError);
endinterface

// File: rtl/instruction_fetch_unit_queue.sv
// instruction_fetch_queue: two-entry FIFO of fetched words with a registered head; flush beats push
module instruction_fetch_queue
  import instruction_fetch_unit_pkg::*;
(
  input  logic clk,
  input  logic resetN,
  input  logic push_i,
  input  logic pop_i,
  input  logic flush_i,
  input  fetch_entry_t entry_i,
  output fetch_entry_t head_o,
  output logic valid_o,
  output logic full_o,
  output logic [1:0] count_o
);
  fetch_entry_t e0_q, e0_d, e1_q, e1_d;
  logic [1:0] count_q, count_d, slot;
  logic do_pop, do_push;
  // next contents: shift on pop, then write the new word into the first free slot
  always_comb begin
    do_pop = pop_i && count_q != 2'd0;
    do_push = push_i && (count_q != 2'd2 || do_pop);
    slot = count_q - {1'b0, do_pop};
    e0_d = do_pop ? e1_q : e0_q;
    e1_d = e1_q;
    if (do_push && slot == 2'd0) e0_d = entry_i;
    if (do_push && slot != 2'd0) e1_d = entry_i;
    count_d = flush_i ? 2'd0 : count_q + {1'b0, do_push} - {1'b0, do_pop};
  end
  // queue storage and occupancy
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      e0_q <= '0;
      e1_q <= '0;
      count_q <= 2'd0;
    end else begin
      e0_q <= e0_d;
      e1_q <= e1_d;
      count_q <= count_d;
    end
  end
  assign head_o = e0_q;
  assign valid_o = count_q != 2'd0;
  assign full_o = count_q == 2'd2;
  assign count_o = count_q;
endmodule

// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: owns the fetch PC, issues word reads and feeds the decoder from a two-entry queue
module instruction_fetch_unit
  import instruction_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_DEFAULT,
  parameter int QUEUE_DEPTH = FETCH_QUEUE_DEPTH
) (
  input  logic clk,
  input  logic resetN,
  instruction_fetch_unit_if.master bus,
  output logic [31:0] currentInstruction,
  output logic [31:0] currentInstructionAddress,
  output logic instructionValid,
  output logic instructionFault,
  input  logic instructionConsume,
  input  logic redirect,
  input  logic [29:0] redirectTarget
);
  fetch_state_e state_q, state_d;
  logic req_q, req_d, fault_stop_q, fault_stop_d;
  logic [29:0] req_addr_q, req_addr_d, fetch_pc_q, fetch_pc_d;
  logic ack, issue, push, pop, q_valid, q_full;
  logic [1:0] q_count, occ;
  fetch_entry_t q_head;
  assign ack = bus.busAcknowledge && req_q;
  // state register
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) state_q <= ST_RUN;
    else state_q <= state_d;
  end
  // a redirect that catches a read in flight must wait for it to finish before refetching
  always_comb begin
    state_d = (state_q == ST_RUN) ? ((redirect && req_q && !bus.busAcknowledge) ? ST_DRAIN : ST_RUN)
                                  : (ack ? ST_RUN : ST_DRAIN);
  end
  // control outputs: redirect outranks consume and push; drained data is never queued
  always_comb begin
    pop = instructionConsume && q_valid && !redirect;
    push = ack && state_q == ST_RUN && !redirect;
    occ = q_count - {1'b0, pop};
    issue = state_q == ST_RUN && !req_q && !redirect && !fault_stop_q && (!q_full || pop)
            && ({1'b0, occ} < 3'(QUEUE_DEPTH));
  end
  // datapath next state: request held until ack, PC advances per queued word
  always_comb begin
    req_d = issue ? 1'b1 : (ack ? 1'b0 : req_q);
    req_addr_d = issue ? fetch_pc_q : req_addr_q;
    fetch_pc_d = redirect ? redirectTarget : (push ? fetch_pc_q + 30'd1 : fetch_pc_q);
    fault_stop_d = redirect ? 1'b0 : ((push && bus.busError) ? 1'b1 : fault_stop_q);
  end
  // datapath registers
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      req_q <= 1'b0;
      req_addr_q <= '0;
      fetch_pc_q <= RESET_VECTOR[31:2];
      fault_stop_q <= 1'b0;
    end else begin
      req_q <= req_d;
      req_addr_q <= req_addr_d;
      fetch_pc_q <= fetch_pc_d;
      fault_stop_q <= fault_stop_d;
    end
  end
  instruction_fetch_queue u_queue (
    .clk(clk),
    .resetN(resetN),
    .push_i(push),
    .pop_i(pop),
    .flush_i(redirect),
    .entry_i('{data: bus.busReadData, addr: req_addr_q, fault: bus.busError}),
    .head_o(q_head),
    .valid_o(q_valid),
    .full_o(q_full),
    .count_o(q_count)
  );
  assign bus.busRequest = req_q;
  assign bus.busAddress = {req_addr_q, 2'b00};
  assign bus.busSize = BUS_SIZE_WORD;
  assign currentInstruction = q_head.data;
  assign currentInstructionAddress = {q_head.addr, 2'b00};
  assign instructionValid = q_valid;
  assign instructionFault = q_head.fault && q_valid;
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb_instruction_fetch_unit: directed cycle table plus hand sequences for reset, fault and PC wrap
module tb_instruction_fetch_unit;
  import instruction_fetch_unit_pkg::*;
  logic clk = 1'b0;
  logic resetN = 1'b0;
  logic instructionConsume = 1'b0;
  logic redirect = 1'b0;
  logic [29:0] redirectTarget = '0;
  logic [31:0] currentInstruction, currentInstructionAddress;
  logic instructionValid, instructionFault;
  int checks = 0;
  int failures = 0;
  instruction_fetch_unit_if bus();
  instruction_fetch_unit dut (
    .clk(clk),
    .resetN(resetN),
    .bus(bus),
    .currentInstruction(currentInstruction),
    .currentInstructionAddress(currentInstructionAddress),
    .instructionValid(instructionValid),
    .instructionFault(instructionFault),
    .instructionConsume(instructionConsume),
    .redirect(redirect),
    .redirectTarget(redirectTarget)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic ack; logic [31:0] rdata; logic err; logic cons; logic redir; logic [29:0] tgt;
    logic e_req; logic [31:0] e_addr; logic e_valid; logic [31:0] e_instr; logic [31:0] e_iaddr; logic e_fault;
  } vec_t;
  vec_t tbl[17];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, act, exp);
    end
  endtask
  task automatic wait_req(input string name, input logic [31:0] a);
    int n = 0;
    while (!bus.busRequest && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_req"}, 32'(bus.busRequest), 32'd1);
    chk({name, "_addr"}, bus.busAddress, a);
  endtask
  task automatic do_ack(input logic [31:0] d, input logic e);
    bus.busAcknowledge = 1'b1;
    bus.busReadData = d;
    bus.busError = e;
    @(negedge clk);
    bus.busAcknowledge = 1'b0;
    bus.busError = 1'b0;
  endtask
  task automatic chk_head(input string name, input logic v, input logic f, input logic [31:0] d, input logic [31:0] a);
    chk({name, "_valid"}, 32'(instructionValid), 32'(v));
    chk({name, "_fault"}, 32'(instructionFault), 32'(f));
    if (v) begin
      chk({name, "_instr"}, currentInstruction, d);
      chk({name, "_iaddr"}, currentInstructionAddress, a);
    end
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end
  initial begin
    tbl[0]  = '{1, 32'h0C000000, 0, 0, 0, 30'h0,   1, 32'hE0000000, 0, 32'h0,        32'h0,        0};
    tbl[1]  = '{0, 32'h0,        0, 0, 0, 30'h0,   0, 32'h0,        1, 32'h0C000000, 32'hE0000000, 0};
    tbl[2]  = '{1, 32'h11111111, 0, 0, 0, 30'h0,   1, 32'hE0000004, 1, 32'h0C000000, 32'hE0000000, 0};
    tbl[3]  = '{0, 32'h0,        0, 0, 0, 30'h0,   0, 32'h0,        1, 32'h0C000000, 32'hE0000000, 0};
    tbl[4]  = '{0, 32'h0,        0, 0, 0, 30'h0,   0, 32'h0,        1, 32'h0C000000, 32'hE0000000, 0};
    tbl[5]  = '{0, 32'h0,        0, 1, 0, 30'h0,   0, 32'h0,        1, 32'h0C000000, 32'hE0000000, 0};
    tbl[6]  = '{0, 32'h0,        0, 0, 1, 30'h100, 1, 32'hE0000008, 1, 32'h11111111, 32'hE0000004, 0};
    tbl[7]  = '{0, 32'h0,        0, 0, 0, 30'h0,   1, 32'hE0000008, 0, 32'h0,        32'h0,        0};
    tbl[8]  = '{0, 32'h0,        0, 0, 0, 30'h0,   1, 32'hE0000008, 0, 32'h0,        32'h0,        0};
    tbl[9]  = '{1, 32'hDEADBEEF, 0, 0, 0, 30'h0,   1, 32'hE0000008, 0, 32'h0,        32'h0,        0};
    tbl[10] = '{0, 32'h0,        0, 0, 0, 30'h0,   0, 32'h0,        0, 32'h0,        32'h0,        0};
    tbl[11] = '{1, 32'h22222222, 0, 0, 0, 30'h0,   1, 32'h00000400, 0, 32'h0,        32'h0,        0};
    tbl[12] = '{0, 32'h0,        0, 0, 0, 30'h0,   0, 32'h0,        1, 32'h22222222, 32'h00000400, 0};
    tbl[13] = '{1, 32'h33333333, 0, 1, 1, 30'h200, 1, 32'h00000404, 1, 32'h22222222, 32'h00000400, 0};
    tbl[14] = '{0, 32'h0,        0, 0, 0, 30'h0,   0, 32'h0,        0, 32'h0,        32'h0,        0};
    tbl[15] = '{1, 32'h44444444, 0, 0, 0, 30'h0,   1, 32'h00000800, 0, 32'h0,        32'h0,        0};
    tbl[16] = '{0, 32'h0,        0, 0, 0, 30'h0,   0, 32'h0,        1, 32'h44444444, 32'h00000800, 0};
    bus.busAcknowledge = 1'b0;
    bus.busReadData = '0;
    bus.busError = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_req", 32'(bus.busRequest), 32'd0);
    chk("rst_valid", 32'(instructionValid), 32'd0);
    chk("rst_fault", 32'(instructionFault), 32'd0);
    chk("rst_instr", currentInstruction, 32'd0);
    chk("rst_iaddr", currentInstructionAddress, 32'd0);
    resetN = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 17; i++) begin
      chk($sformatf("row%0d_req", i), 32'(bus.busRequest), 32'(tbl[i].e_req));
      chk($sformatf("row%0d_size", i), 32'(bus.busSize), 32'(BUS_SIZE_WORD));
      if (tbl[i].e_req) chk($sformatf("row%0d_addr", i), bus.busAddress, tbl[i].e_addr);
      chk_head($sformatf("row%0d", i), tbl[i].e_valid, tbl[i].e_fault, tbl[i].e_instr, tbl[i].e_iaddr);
      bus.busAcknowledge = tbl[i].ack;
      bus.busReadData = tbl[i].rdata;
      bus.busError = tbl[i].err;
      instructionConsume = tbl[i].cons;
      redirect = tbl[i].redir;
      redirectTarget = tbl[i].tgt;
      @(negedge clk);
    end
    bus.busAcknowledge = 1'b0;
    instructionConsume = 1'b0;
    redirect = 1'b0;
    chk("mid_req", 32'(bus.busRequest), 32'd1);
    #2 resetN = 1'b0;
    #1;
    chk("async_req", 32'(bus.busRequest), 32'd0);
    chk("async_valid", 32'(instructionValid), 32'd0);
    @(negedge clk);
    resetN = 1'b1;
    wait_req("f0", 32'hE0000000);
    do_ack(32'hA0A0A0A0, 1'b0);
    wait_req("f1", 32'hE0000004);
    do_ack(32'hBAD0BAD0, 1'b1);
    chk_head("pre_fault", 1'b1, 1'b0, 32'hA0A0A0A0, 32'hE0000000);
    instructionConsume = 1'b1;
    @(negedge clk);
    instructionConsume = 1'b0;
    chk_head("fault_head", 1'b1, 1'b1, 32'hBAD0BAD0, 32'hE0000004);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("stop%0d_req", i), 32'(bus.busRequest), 32'd0);
      @(negedge clk);
    end
    redirect = 1'b1;
    redirectTarget = 30'h3FFFFFFF;
    @(negedge clk);
    redirect = 1'b0;
    chk_head("redir_clear", 1'b0, 1'b0, 32'h0, 32'h0);
    wait_req("w0", 32'hFFFFFFFC);
    do_ack(32'h55555555, 1'b0);
    wait_req("w1", 32'h00000000);
    chk_head("wrap_head0", 1'b1, 1'b0, 32'h55555555, 32'hFFFFFFFC);
    do_ack(32'h66666666, 1'b0);
    chk_head("wrap_full", 1'b1, 1'b0, 32'h55555555, 32'hFFFFFFFC);
    instructionConsume = 1'b1;
    @(negedge clk);
    instructionConsume = 1'b0;
    chk_head("wrap_head1", 1'b1, 1'b0, 32'h66666666, 32'h00000000);
    wait_req("w2", 32'h00000004);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
